// File: rtl/rv_pkg.sv
// Shared RV32I decode/ALU definitions: opcodes, ALU control encodings, decoded slot payload.
package rv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned ALU_CTRL_W = 10;
  localparam int unsigned ILL_CNT_W  = 8;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  // ALU control = {funct7, funct3}
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 10'b0000000_000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 10'b0100000_000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 10'b0000000_001;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 10'b0000000_010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 10'b0000000_011;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 10'b0000000_100;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 10'b0000000_101;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 10'b0100000_101;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 10'b0000000_110;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 10'b0000000_111;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_U    = 3'd3,
    IMM_SH   = 3'd4
  } imm_fmt_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_e;

  typedef struct packed {
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic [XLEN-1:0]       imm;
    logic                  imm_en;
    logic [REG_W-1:0]      rs1;
    logic [REG_W-1:0]      rs2;
    logic [REG_W-1:0]      rd;
    logic                  reg_we;
    logic                  mem_rd;
    logic                  mem_wr;
    logic                  illegal;
  } dec_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate selection and sign extension for the decoder; purely combinational.
module imm_gen
  import rv_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  input  logic [2:0]      fmt,
  output logic [XLEN-1:0] imm
);

  // Opcode bits never contribute to an immediate
  logic unused_opc;
  assign unused_opc = ^instr[6:0];

  // Pick the immediate layout for the instruction format
  always_comb begin
    imm = '0;
    case (imm_fmt_e'(fmt))
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_SH:  imm = {27'b0, instr[24:20]};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/instr_decode.sv
// RV32I subset decoder with a single registered output slot and RUN/TRAP control.
module instr_decode
  import rv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       instr,
  input  logic                  flush,
  input  logic                  trap_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [XLEN-1:0]       imm,
  output logic                  imm_en,
  output logic [REG_W-1:0]      rs1,
  output logic [REG_W-1:0]      rs2,
  output logic [REG_W-1:0]      rd,
  output logic                  reg_we,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic                  illegal,
  output logic [ILL_CNT_W-1:0]  illegal_cnt
);

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [REG_W-1:0] rs1_f;
  logic [REG_W-1:0] rs2_f;
  logic [REG_W-1:0] rd_f;

  imm_fmt_e         fmt_c;
  logic [XLEN-1:0]  imm_c;
  logic             op_legal_c;
  logic             is_shift_c;
  dec_t             dec_c;
  logic             load_c;

  dec_t             slot_q;
  state_e           state_q;
  state_e           state_d;
  logic [ILL_CNT_W-1:0] cnt_q;

  assign opcode = instr[6:0];
  assign rd_f   = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1_f  = instr[19:15];
  assign rs2_f  = instr[24:20];
  assign funct7 = instr[31:25];

  assign op_legal_c = (funct7 == F7_BASE) ||
                      ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
  assign is_shift_c = (funct3 == F3_SLL) || (funct3 == F3_SR);

  // A new word is taken only when no flush discards it
  assign in_ready = (state_q == ST_RUN) && (!out_valid || out_ready);
  assign load_c   = in_valid && in_ready && !flush;

  // Immediate format from the opcode; shifts carry only shamt
  always_comb begin
    fmt_c = IMM_NONE;
    case (opcode)
      OPC_OP_IMM: fmt_c = is_shift_c ? IMM_SH : IMM_I;
      OPC_LOAD:   fmt_c = IMM_I;
      OPC_STORE:  fmt_c = IMM_S;
      OPC_LUI:    fmt_c = IMM_U;
      default:    fmt_c = IMM_NONE;
    endcase
  end

  imm_gen u_imm_gen (
    .instr (instr),
    .fmt   (fmt_c),
    .imm   (imm_c)
  );

  // Field decode; unused register indices are zeroed, illegal slots carry no enables
  always_comb begin
    dec_c = '0;
    case (opcode)
      OPC_OP: begin
        if (op_legal_c) begin
          dec_c.alu_ctrl = {funct7, funct3};
          dec_c.rs1      = rs1_f;
          dec_c.rs2      = rs2_f;
          dec_c.rd       = rd_f;
          dec_c.reg_we   = 1'b1;
        end else begin
          dec_c.illegal  = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_c.alu_ctrl = {(is_shift_c ? funct7 : F7_BASE), funct3};
        dec_c.imm      = imm_c;
        dec_c.imm_en   = 1'b1;
        dec_c.rs1      = rs1_f;
        dec_c.rd       = rd_f;
        dec_c.reg_we   = 1'b1;
      end
      OPC_LUI: begin
        dec_c.alu_ctrl = ALU_ADD;
        dec_c.imm      = imm_c;
        dec_c.imm_en   = 1'b1;
        dec_c.rd       = rd_f;
        dec_c.reg_we   = 1'b1;
      end
      OPC_LOAD: begin
        dec_c.alu_ctrl = ALU_ADD;
        dec_c.imm      = imm_c;
        dec_c.imm_en   = 1'b1;
        dec_c.rs1      = rs1_f;
        dec_c.rd       = rd_f;
        dec_c.reg_we   = 1'b1;
        dec_c.mem_rd   = 1'b1;
      end
      OPC_STORE: begin
        dec_c.alu_ctrl = ALU_ADD;
        dec_c.imm      = imm_c;
        dec_c.imm_en   = 1'b1;
        dec_c.rs1      = rs1_f;
        dec_c.rs2      = rs2_f;
        dec_c.mem_wr   = 1'b1;
      end
      default: dec_c.illegal = 1'b1;
    endcase
  end

  // Next state: only an accepted illegal word traps; trap_clr leaves TRAP
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (load_c && dec_c.illegal) state_d = ST_TRAP;
      ST_TRAP: if (trap_clr)                state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Decode slot: load wins, otherwise flush or consumption empties it; fields hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q    <= '0;
      out_valid <= 1'b0;
    end else if (load_c) begin
      slot_q    <= dec_c;
      out_valid <= 1'b1;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of accepted illegal words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          cnt_q <= '0;
    else if (load_c && dec_c.illegal && (cnt_q != '1))   cnt_q <= cnt_q + ILL_CNT_W'(1);
  end

  assign alu_ctrl    = slot_q.alu_ctrl;
  assign imm         = slot_q.imm;
  assign imm_en      = slot_q.imm_en;
  assign rs1         = slot_q.rs1;
  assign rs2         = slot_q.rs2;
  assign rd          = slot_q.rd;
  assign reg_we      = slot_q.reg_we;
  assign mem_rd      = slot_q.mem_rd;
  assign mem_wr      = slot_q.mem_wr;
  assign illegal     = slot_q.illegal;
  assign illegal_cnt = cnt_q;

endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port in_valid  input  1  instruction word present on instr.
REQ-004 SHALL have port in_ready  output  1  decoder accepts instr this cycle.
REQ-005 SHALL have port instr  input  32  RV32I instruction word.
REQ-006 SHALL have port flush  input  1  discard held decoded instruction.
REQ-007 SHALL have port trap_clr  input  1  leave TRAP state.
REQ-008 SHALL have port out_valid  output  1  decoded fields valid.
REQ-009 SHALL have port out_ready  input  1  execute stage consumes decoded fields.
REQ-010 SHALL have port alu_ctrl  output  10  ALU control, {funct7, funct3}.
REQ-011 SHALL have port imm  output  32  sign-extended immediate.
REQ-012 SHALL have port imm_en  output  1  ALU uses imm instead of busB.
REQ-013 SHALL have ports rs1, rs2, rd  output  5 each  register indices.
REQ-014 SHALL have ports reg_we, mem_rd, mem_wr  output  1 each  writeback/load/store enables.
REQ-015 SHALL have port illegal  output  1  held instruction is unsupported.
REQ-016 SHALL have port illegal_cnt  output  8  saturating count of illegal instructions accepted.

Function
REQ-017 SHALL hold one registered decode slot; latency from accepted instr to out_valid = 1 cycle.
REQ-018 SHALL drive in_ready = (state==RUN) && (!out_valid || out_ready).
REQ-019 SHALL load the slot when in_valid && in_ready; out_valid SHALL clear when out_ready && out_valid && no new load.
REQ-020 SHALL keep all outputs stable while out_valid && !out_ready.
REQ-021 SHALL support OP (0110011): alu_ctrl={funct7,funct3}, imm_en=0, reg_we=1.
REQ-022 SHALL support OP-IMM (0010011): imm_en=1, reg_we=1, imm=I-type; alu_ctrl[9:3]=instr[31:25] for funct3 001/101, else 0000000.
REQ-023 SHALL support LUI (0110111): rs1=0, imm={instr[31:12],12'b0}, alu_ctrl=ADD, imm_en=1, reg_we=1.
REQ-024 SHALL support LOAD (0000011) and STORE (0100011): alu_ctrl=ADD, imm_en=1, I-/S-type imm; LOAD sets mem_rd, reg_we; STORE sets mem_wr, reg_we=0.
REQ-025 SHALL flag illegal for any other opcode, OP with funct7 not 0000000/0100000, or 0100000 with funct3 not 000/101; illegal slot SHALL have reg_we=mem_rd=mem_wr=0.
REQ-026 SHALL implement FSM RUN/TRAP: RUN->TRAP when an illegal instruction is loaded; TRAP->RUN on trap_clr; in TRAP in_ready=0.
REQ-027 SHALL increment illegal_cnt on each illegal load, saturating at 255.
REQ-028 SHALL on flush clear out_valid next cycle, ignore a simultaneous load, and not change state or illegal_cnt.
REQ-029 SHALL give trap_clr priority over a same-cycle transition into TRAP only when the slot loaded is legal.

Reset
REQ-030 SHALL on rst_n low asynchronously set state=RUN, out_valid=0, illegal=0, illegal_cnt=0, all field outputs=0.
REQ-031 SHALL drop any in-flight decoded instruction when reset asserts mid-operation; first acceptance possible in the cycle after rst_n rises.

Structure
REQ-032 SHALL take opcode constants and ALU_* ctrl encodings from shared package rv_pkg, also used by the ALU.
REQ-033 SHALL place immediate selection/sign-extension in sub-module imm_gen (combinational, instr and format in, 32-bit imm out).

Verification
REQ-034 SHALL cover 0x002081B3 (add x3,x1,x2) -> next cycle out_valid=1, alu_ctrl=0000000000, rs1=1, rs2=2, rd=3, imm_en=0, reg_we=1; 0x402081B3 -> alu_ctrl=0100000000.
REQ-035 SHALL cover 0x40335293 (srai x5,x6,3) -> alu_ctrl=0100000101, imm=0x00000003, imm_en=1; 0x80012093 (slti x1,x2,-2048) -> alu_ctrl=0000000010, imm=0xFFFFF800.
REQ-036 SHALL cover 0x123453B7 (lui x7) -> rs1=0, imm=0x12345000, alu_ctrl=0000000000, imm_en=1.
REQ-037 SHALL cover out_ready=0 for 3 cycles with in_valid=1 -> outputs frozen, in_ready=0; out_ready=1 -> next instr loaded the following cycle, none lost or duplicated.
REQ-038 SHALL cover 0x00000000 -> illegal=1, illegal_cnt=1, in_ready=0 until trap_clr pulse, then RUN; 256 illegals -> illegal_cnt=255.
REQ-039 SHALL cover flush and rst_n asserted while out_valid=1 -> out_valid=0 next cycle (flush) or immediately (reset), no output reaches execute.
